// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 responder backed by a word-addressed on-chip SRAM.
// Serves single-beat FIXED and up to 256-beat INCR bursts of 32-bit words.
// Optional build macro AXI_SLAVE_WAIT_EN inserts WAIT_CYCLES wait states
// between each address handshake and the first data beat of that direction.
module axi_sram_slave #(
  parameter int unsigned DEPTH       = 65536,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  // read address channel
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  // read data channel
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // write address channel
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  // write data channel
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // write response channel
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

`ifdef AXI_SLAVE_WAIT_EN
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_DATA, W_RESP} wr_state_t;
  logic [3:0] r_wcnt;
  logic [3:0] w_wcnt;
`else
  typedef enum logic [1:0] {R_IDLE, R_BURST} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
`endif

  logic [31:0] mem [DEPTH];

  rd_state_t   rd_state;
  logic [29:0] r_idx;
  logic [29:0] r_idx_nxt;
  logic [7:0]  r_len;
  logic [7:0]  r_beat;
  logic        r_fixed;
  logic [29:0] rd_addr;
  logic [31:0] rd_word;
  logic        rd_oob;

  wr_state_t   wr_state;
  logic [3:0]  w_id;
  logic [29:0] w_idx;
  logic [29:0] w_idx_nxt;
  logic [7:0]  w_len;
  logic [7:0]  w_beat;
  logic        w_fixed;
  logic        w_err;
  logic        w_err_nxt;
  logic        w_last_beat;
  logic        w_oob;
  logic        mem_we;

  // Inputs the slave does not interpret (size, lock, cache, prot, wid, byte offset)
  logic unused_inputs;
  assign unused_inputs = ^{araddr[1:0], arsize, arlock, arcache, arprot,
                           awaddr[1:0], awsize, awlock, awcache, awprot, wid,
                           4'(WAIT_CYCLES)};

  // Read-port address: the word whose data lands in rdata at the next edge
  always_comb begin
    r_idx_nxt = r_fixed ? r_idx : r_idx + 30'd1;
    rd_addr   = r_idx_nxt;
    case (rd_state)
      R_IDLE:  rd_addr = araddr[31:2];
`ifdef AXI_SLAVE_WAIT_EN
      R_WAIT:  rd_addr = r_idx;
`endif
      default: rd_addr = r_idx_nxt;
    endcase
    rd_oob  = !(rd_addr < DEPTH_W);
    rd_word = mem[rd_addr[AW-1:0]];
  end

  // Read FSM: accept AR, then stream len+1 beats with registered payload
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state <= R_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rid      <= '0;
      rdata    <= '0;
      rresp    <= '0;
      r_idx    <= '0;
      r_len    <= '0;
      r_beat   <= '0;
      r_fixed  <= 1'b0;
`ifdef AXI_SLAVE_WAIT_EN
      r_wcnt   <= '0;
`endif
    end else begin
      case (rd_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            arready <= 1'b0;
            rid     <= arid;
            r_idx   <= araddr[31:2];
            r_len   <= arlen;
            r_beat  <= '0;
            r_fixed <= (arburst == 2'd0);
`ifdef AXI_SLAVE_WAIT_EN
            if (WAIT_CYCLES != 0) begin
              r_wcnt   <= '0;
              rd_state <= R_WAIT;
            end else begin
`endif
              rvalid   <= 1'b1;
              rdata    <= rd_oob ? '0 : rd_word;
              rresp    <= rd_oob ? 2'b10 : 2'b00;
              rlast    <= (arlen == 8'd0);
              rd_state <= R_BURST;
`ifdef AXI_SLAVE_WAIT_EN
            end
`endif
          end
        end
`ifdef AXI_SLAVE_WAIT_EN
        R_WAIT: begin
          if (r_wcnt == 4'(WAIT_CYCLES - 1)) begin
            rvalid   <= 1'b1;
            rdata    <= rd_oob ? '0 : rd_word;
            rresp    <= rd_oob ? 2'b10 : 2'b00;
            rlast    <= (r_len == 8'd0);
            rd_state <= R_BURST;
          end else begin
            r_wcnt <= r_wcnt + 4'd1;
          end
        end
`endif
        R_BURST: begin
          if (rready) begin
            if (rlast) begin
              rvalid   <= 1'b0;
              rlast    <= 1'b0;
              arready  <= 1'b1;
              rd_state <= R_IDLE;
            end else begin
              r_beat <= r_beat + 8'd1;
              r_idx  <= r_idx_nxt;
              rdata  <= rd_oob ? '0 : rd_word;
              rresp  <= rd_oob ? 2'b10 : 2'b00;
              rlast  <= ((r_beat + 8'd1) == r_len);
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Write-beat qualification and sticky error accumulation
  always_comb begin
    w_idx_nxt   = w_fixed ? w_idx : w_idx + 30'd1;
    w_last_beat = (w_beat == w_len);
    w_oob       = !(w_idx < DEPTH_W);
    w_err_nxt   = w_err | w_oob | (wlast != w_last_beat);
    mem_we      = (wr_state == W_DATA) && wvalid && wready && !w_oob;
  end

  // Write FSM: accept AW, take len+1 W beats, then issue one B response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state <= W_IDLE;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bid      <= '0;
      bresp    <= '0;
      w_id     <= '0;
      w_idx    <= '0;
      w_len    <= '0;
      w_beat   <= '0;
      w_fixed  <= 1'b0;
      w_err    <= 1'b0;
`ifdef AXI_SLAVE_WAIT_EN
      w_wcnt   <= '0;
`endif
    end else begin
      case (wr_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            awready <= 1'b0;
            w_id    <= awid;
            w_idx   <= awaddr[31:2];
            w_len   <= awlen;
            w_beat  <= '0;
            w_fixed <= (awburst == 2'd0);
            w_err   <= 1'b0;
`ifdef AXI_SLAVE_WAIT_EN
            if (WAIT_CYCLES != 0) begin
              w_wcnt   <= '0;
              wr_state <= W_WAIT;
            end else begin
`endif
              wready   <= 1'b1;
              wr_state <= W_DATA;
`ifdef AXI_SLAVE_WAIT_EN
            end
`endif
          end
        end
`ifdef AXI_SLAVE_WAIT_EN
        W_WAIT: begin
          if (w_wcnt == 4'(WAIT_CYCLES - 1)) begin
            wready   <= 1'b1;
            wr_state <= W_DATA;
          end else begin
            w_wcnt <= w_wcnt + 4'd1;
          end
        end
`endif
        W_DATA: begin
          if (wvalid && wready) begin
            w_err <= w_err_nxt;
            if (w_last_beat) begin
              wready   <= 1'b0;
              bvalid   <= 1'b1;
              bid      <= w_id;
              bresp    <= w_err_nxt ? 2'b10 : 2'b00;
              wr_state <= W_RESP;
            end else begin
              w_beat <= w_beat + 8'd1;
              w_idx  <= w_idx_nxt;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid   <= 1'b0;
            w_err    <= 1'b0;
            awready  <= 1'b1;
            wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Memory write port with per-byte lane enables
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[w_idx[AW-1:0]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: self-checking bench for axi_sram_slave (default build,
// AXI_SLAVE_WAIT_EN undefined). Inputs change and outputs are sampled on the
// falling clock edge; handshakes happen on the rising edge.
`timescale 1ns/1ps
module tb_axi_sram_slave;

  localparam int unsigned TB_DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = 3'b010;
  logic [1:0]  arburst = '0;
  logic [1:0]  arlock = '0;
  logic [3:0]  arcache = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = 3'b010;
  logic [1:0]  awburst = '0;
  logic [1:0]  awlock = '0;
  logic [3:0]  awcache = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [3:0]  wid = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;

  always #5 clk = ~clk;

  axi_sram_slave #(.DEPTH(TB_DEPTH), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int asserts = 0;
  int fails   = 0;

  // Reference memory: only words whose full contents are known are present
  logic [31:0] model [logic [29:0]];

  // Per-transaction buffers shared between the stimulus tasks and the checks
  logic [31:0] wr_data [256];
  logic [3:0]  wr_strb [256];
  logic [3:0]  wr_bid;
  logic [1:0]  wr_bresp;
  logic [31:0] rd_data [256];
  logic [1:0]  rd_resp [256];
  logic        rd_last [256];
  logic [3:0]  rd_id   [256];
  int          rd_n;
  int          rd_gaps;
  logic        rd_lat_ok;
  logic        rd_end_rvalid;
  logic        rd_end_arready;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] init;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } strb_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bound(input string name, input bit ok);
    asserts++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: handshake did not occur within the cycle budget", name);
    end
  endtask

  function automatic logic [29:0] beat_idx(input logic [31:0] addr, input logic [1:0] burst, input int b);
    if (burst == 2'd0) return addr[31:2];
    return addr[31:2] + 30'(b);
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // Applies a write burst from wr_data/wr_strb to the reference memory and
  // returns the response the slave should give.
  task automatic model_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input int bad, output logic [1:0] exp_bresp);
    bit err;
    logic [29:0] i;
    logic [31:0] m;
    err = (bad >= 0) && (bad <= int'(len));
    for (int b = 0; b <= int'(len); b++) begin
      i = beat_idx(addr, burst, b);
      if (i >= 30'(TB_DEPTH)) err = 1'b1;
      else if (model.exists(i)) begin
        m = lane_mask(wr_strb[b]);
        model[i] = (model[i] & ~m) | (wr_data[b] & m);
      end else if (wr_strb[b] == 4'hF) model[i] = wr_data[b];
    end
    exp_bresp = err ? 2'b10 : 2'b00;
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int bad);
    int t;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    bound("aw_accept", t < 50);
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wdata = wr_data[b]; wstrb = wr_strb[b];
      wlast = (b == int'(len)) ^ (b == bad);
      wvalid = 1'b1;
      t = 0;
      while (!wready && t < 50) begin @(negedge clk); t++; end
      bound("w_accept", t < 50);
      @(posedge clk);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    t = 0;
    while (!bvalid && t < 50) begin @(negedge clk); t++; end
    bound("b_valid", t < 50);
    wr_bid = bid; wr_bresp = bresp;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reads a burst with rready high, except for a 3-cycle stall when beat
  // stall_beat is presented (stall_beat < 0 means no stall).
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int stall_beat);
    int t, cyc, stalls;
    logic [31:0] hold_d;
    logic        hold_l;
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1; rready = 1'b1;
    t = 0;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    bound("ar_accept", t < 50);
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    rd_lat_ok = rvalid;
    rd_n = 0; rd_gaps = 0; cyc = 0; stalls = 3;
    hold_d = '0; hold_l = 1'b0;
    while (rd_n <= int'(len) && cyc < 2000) begin
      if (rvalid) begin
        if (rd_n == stall_beat && stalls > 0) begin
          if (stalls == 3) begin
            hold_d = rdata; hold_l = rlast;
          end else begin
            check("stall_rdata_held", rdata, hold_d);
            check("stall_rlast_held", 32'(rlast), 32'(hold_l));
          end
          rready = 1'b0;
          stalls--;
        end else begin
          rready = 1'b1;
          rd_data[rd_n] = rdata; rd_resp[rd_n] = rresp;
          rd_last[rd_n] = rlast; rd_id[rd_n] = rid;
          rd_n++;
        end
      end else rd_gaps++;
      @(negedge clk);
      cyc++;
    end
    bound("r_burst_complete", rd_n == int'(len) + 1);
    rd_end_rvalid = rvalid;
    rd_end_arready = arready;
  endtask

  // Compares the last read burst against the reference memory.
  task automatic check_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst);
    logic [29:0] i;
    for (int b = 0; b < rd_n && b <= int'(len); b++) begin
      i = beat_idx(addr, burst, b);
      check("rnd_rid", 32'(rd_id[b]), 32'(id));
      check("rnd_rlast", 32'(rd_last[b]), 32'(b == int'(len)));
      if (i >= 30'(TB_DEPTH)) begin
        check("rnd_rresp_oob", 32'(rd_resp[b]), 32'h2);
        check("rnd_rdata_oob", rd_data[b], 32'h0);
      end else begin
        check("rnd_rresp", 32'(rd_resp[b]), 32'h0);
        if (model.exists(i)) check("rnd_rdata", rd_data[b], model[i]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails + 0);
    $fatal(1);
  end

  initial begin
    strb_vec_t   vecs [6];
    logic [1:0]  exp_b;
    logic [31:0] a;
    logic [7:0]  l;
    logic [1:0]  bu;
    logic [3:0]  id;
    int          bad, stall, t;

    vecs[0] = '{32'h0000_0200, 32'hFFFF_FFFF, 32'h1234_5678, 4'b0011, 32'hFFFF_5678};
    vecs[1] = '{32'h0000_0204, 32'h0000_0000, 32'hAABB_CCDD, 4'b1000, 32'hAA00_0000};
    vecs[2] = '{32'h0000_0208, 32'h1111_1111, 32'hA5A5_A5A5, 4'b0101, 32'h11A5_11A5};
    vecs[3] = '{32'h0000_020C, 32'h1234_5678, 32'h0000_0000, 4'b0000, 32'h1234_5678};
    vecs[4] = '{32'h0000_0210, 32'h0000_0000, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D};
    vecs[5] = '{32'h0000_0217, 32'h0000_0000, 32'h8765_4321, 4'b1100, 32'h8765_0000};

    // Reset: outputs low while held, ready one edge after release
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("reset_ctrl", {14'b0, arready, awready, wready, rvalid, rlast, bvalid, rid, bid, rresp, bresp}, 32'h0);
      check("reset_rdata", rdata, 32'h0);
    end
    rst = 1'b1;
    #1;
    check("arready_before_edge", 32'(arready), 32'h0);
    @(negedge clk);
    check("arready_after_release", 32'(arready), 32'h1);
    check("awready_after_release", 32'(awready), 32'h1);

    // Single write then read
    wr_data[0] = 32'hDEAD_BEEF; wr_strb[0] = 4'hF;
    model_write(32'h10, 8'd0, 2'd0, -1, exp_b);
    axi_write(4'd3, 32'h10, 8'd0, 2'd0, -1);
    check("single_bid", 32'(wr_bid), 32'd3);
    check("single_bresp", 32'(wr_bresp), 32'h0);
    axi_read(4'd5, 32'h10, 8'd0, 2'd0, -1);
    check("single_rdata", rd_data[0], 32'hDEAD_BEEF);
    check("single_rid", 32'(rd_id[0]), 32'd5);
    check("single_rlast", 32'(rd_last[0]), 32'h1);
    check("single_rresp", 32'(rd_resp[0]), 32'h0);
    check("single_latency", 32'(rd_lat_ok), 32'h1);
    check("single_end_rvalid", 32'(rd_end_rvalid), 32'h0);
    check("single_end_arready", 32'(rd_end_arready), 32'h1);

    // 16-beat INCR burst write and read-back
    for (int b = 0; b < 16; b++) begin wr_data[b] = 32'(b); wr_strb[b] = 4'hF; end
    model_write(32'h100, 8'd15, 2'd1, -1, exp_b);
    axi_write(4'd1, 32'h100, 8'd15, 2'd1, -1);
    check("incr_bresp", 32'(wr_bresp), 32'h0);
    axi_read(4'd2, 32'h100, 8'd15, 2'd1, -1);
    for (int b = 0; b < 16; b++) begin
      check("incr_rdata", rd_data[b], 32'(b));
      check("incr_rlast", 32'(rd_last[b]), 32'(b == 15));
    end
    check("incr_consecutive", 32'(rd_gaps), 32'h0);

    // Read backpressure at beat 4
    axi_read(4'd6, 32'h100, 8'd15, 2'd1, 4);
    for (int b = 0; b < 16; b++) check("stall_rdata", rd_data[b], 32'(b));
    check("stall_beats", 32'(rd_n), 32'd16);

    // Byte-strobe table
    for (int v = 0; v < 6; v++) begin
      wr_data[0] = vecs[v].init; wr_strb[0] = 4'hF;
      model_write(vecs[v].addr, 8'd0, 2'd0, -1, exp_b);
      axi_write(4'd4, vecs[v].addr, 8'd0, 2'd0, -1);
      wr_data[0] = vecs[v].data; wr_strb[0] = vecs[v].strb;
      model_write(vecs[v].addr, 8'd0, 2'd0, -1, exp_b);
      axi_write(4'd4, vecs[v].addr, 8'd0, 2'd0, -1);
      check("strb_bresp", 32'(wr_bresp), 32'h0);
      axi_read(4'd8, vecs[v].addr, 8'd0, 2'd0, -1);
      check("strb_rdata", rd_data[0], vecs[v].exp);
    end

    // W beats presented before any AW are not accepted
    @(negedge clk);
    wdata = 32'h5555_AAAA; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("w_before_aw", 32'(wready), 32'h0);
    end
    wvalid = 1'b0; wlast = 1'b0;

    // Fill words 1000..1023 (up to the last valid index)
    for (int b = 0; b < 24; b++) begin wr_data[b] = $urandom; wr_strb[b] = 4'hF; end
    model_write(32'(1000 * 4), 8'd23, 2'd1, -1, exp_b);
    axi_write(4'd0, 32'(1000 * 4), 8'd23, 2'd1, -1);
    check("fill_bresp", 32'(wr_bresp), 32'h0);

    // Out-of-range read, and an INCR read crossing the top of memory
    axi_read(4'd7, 32'(TB_DEPTH * 4), 8'd0, 2'd0, -1);
    check("oob_rresp", 32'(rd_resp[0]), 32'h2);
    check("oob_rdata", rd_data[0], 32'h0);
    check("oob_rlast", 32'(rd_last[0]), 32'h1);
    axi_read(4'd7, 32'((TB_DEPTH - 1) * 4), 8'd1, 2'd1, -1);
    check_read(4'd7, 32'((TB_DEPTH - 1) * 4), 8'd1, 2'd1);

    // Early wlast on beat 2 of a len-3 burst: error reported, data still written
    for (int b = 0; b < 4; b++) begin wr_data[b] = 32'hA0 + 32'(b); wr_strb[b] = 4'hF; end
    model_write(32'h300, 8'd3, 2'd1, 2, exp_b);
    axi_write(4'd11, 32'h300, 8'd3, 2'd1, 2);
    check("wlast_err_bresp", 32'(wr_bresp), 32'h2);
    check("wlast_err_bid", 32'(wr_bid), 32'd11);
    axi_read(4'd12, 32'h300, 8'd3, 2'd1, -1);
    for (int b = 0; b < 4; b++) check("wlast_err_data", rd_data[b], 32'hA0 + 32'(b));

    // Out-of-range write errors, and the error does not stick to the next one
    wr_data[0] = 32'h1357_9BDF; wr_strb[0] = 4'hF;
    axi_write(4'd13, 32'(TB_DEPTH * 4), 8'd0, 2'd0, -1);
    check("oob_write_bresp", 32'(wr_bresp), 32'h2);
    model_write(32'h320, 8'd0, 2'd0, -1, exp_b);
    axi_write(4'd14, 32'h320, 8'd0, 2'd0, -1);
    check("err_cleared_bresp", 32'(wr_bresp), 32'h0);

    // Concurrent AR and AW in the same cycle
    for (int b = 0; b < 4; b++) begin wr_data[b] = 32'hC0DE_0000 + 32'(b); wr_strb[b] = 4'hF; end
    model_write(32'h400, 8'd3, 2'd1, -1, exp_b);
    fork
      axi_write(4'd9, 32'h400, 8'd3, 2'd1, -1);
      axi_read(4'd10, 32'h100, 8'd15, 2'd1, -1);
    join
    check("conc_bid", 32'(wr_bid), 32'd9);
    check("conc_bresp", 32'(wr_bresp), 32'h0);
    for (int b = 0; b < 16; b++) check("conc_rdata", rd_data[b], 32'(b));
    check("conc_rid", 32'(rd_id[15]), 32'd10);
    axi_read(4'd10, 32'h400, 8'd3, 2'd1, -1);
    for (int b = 0; b < 4; b++) check("conc_readback", rd_data[b], 32'hC0DE_0000 + 32'(b));

    // Reset asserted while beat 7 of a burst is on the bus
    @(negedge clk);
    arid = 4'd1; araddr = 32'h100; arlen = 8'd15; arburst = 2'd1; arvalid = 1'b1; rready = 1'b1;
    t = 0;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    bound("rst_ar_accept", t < 50);
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    t = 0;
    while (!(rvalid && rdata == 32'd7) && t < 50) begin @(negedge clk); t++; end
    bound("rst_reach_beat7", t < 50);
    rst = 1'b0;
    #1;
    check("midrst_rvalid", 32'(rvalid), 32'h0);
    check("midrst_rlast", 32'(rlast), 32'h0);
    check("midrst_arready", 32'(arready), 32'h0);
    check("midrst_rdata", rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("postrst_arready", 32'(arready), 32'h1);
    check("postrst_rvalid", 32'(rvalid), 32'h0);
    axi_read(4'd3, 32'h104, 8'd0, 2'd0, -1);
    check("postrst_read", rd_data[0], 32'd1);

    // Randomized traffic around the top of memory against the reference model
    for (int n = 0; n < 40; n++) begin
      a  = 32'($urandom_range(1000, 1031)) * 4 + 32'($urandom_range(0, 3));
      l  = 8'($urandom_range(0, 7));
      bu = 2'($urandom_range(0, 3));
      id = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        for (int b = 0; b <= int'(l); b++) begin
          wr_data[b] = $urandom; wr_strb[b] = 4'($urandom_range(0, 15));
        end
        bad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(l))) : -1;
        model_write(a, l, bu, bad, exp_b);
        axi_write(id, a, l, bu, bad);
        check("rnd_bid", 32'(wr_bid), 32'(id));
        check("rnd_bresp", 32'(wr_bresp), 32'(exp_b));
      end else begin
        stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(l))) : -1;
        axi_read(id, a, l, bu, stall);
        check_read(id, a, l, bu);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
